wb_gpio: RTL and testbench

//  Parametrised Wishbone GPIO peripheral; successor to the fixed-width LED output block.

---
 rtl/wb_gpio.sv | 128 ++++++++++++
 tb/tb_wb_gpio.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_gpio.sv
// Wishbone B4 pipelined GPIO peripheral: per-pin direction, synchronised input readback,
// atomic SET/CLR/TOGGLE on the output register and sticky edge interrupts.
module wb_gpio #(
  parameter int unsigned N           = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [N-1:0] OUT_RESET  = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_wb_cyc,
  input  logic         i_wb_stb,
  input  logic         i_wb_we,
  input  logic [3:0]   i_wb_sel,
  input  logic [11:2]  i_wb_adr,
  input  logic [31:0]  i_wb_dat,
  output logic [31:0]  o_wb_dat,
  output logic         o_wb_ack,
  output logic         o_wb_stall,
  output logic         o_wb_err,
  input  logic [N-1:0] i_gpio,
  output logic [N-1:0] o_gpio,
  output logic [N-1:0] o_gpio_oe,
  output logic         o_irq
);

  localparam logic [9:0] A_DOUT = 10'd0;
  localparam logic [9:0] A_DIN  = 10'd1;
  localparam logic [9:0] A_DIR  = 10'd2;
  localparam logic [9:0] A_EN   = 10'd3;
  localparam logic [9:0] A_RISE = 10'd4;
  localparam logic [9:0] A_FALL = 10'd5;
  localparam logic [9:0] A_STAT = 10'd6;
  localparam logic [9:0] A_SET  = 10'd7;
  localparam logic [9:0] A_CLR  = 10'd8;
  localparam logic [9:0] A_TOG  = 10'd9;
  localparam logic [2:0] WARM_DONE = 3'(SYNC_STAGES + 1);

  logic [N-1:0] r_out, r_dir, r_en, r_rise, r_fall, r_stat, r_prev;
  logic [N-1:0] r_sync [SYNC_STAGES];
  logic [2:0]   r_warm;
  logic         r_ack, r_irq;
  logic [31:0]  r_dat;

  logic         w_req, w_wr;
  logic [31:0]  w_bm, w_wd, w_rd;
  logic [N-1:0] w_bmn, w_wdn, w_sync, w_edge, w_clr;
  logic         w_unused_hi;

  assign w_req  = i_wb_cyc & i_wb_stb;
  assign w_wr   = w_req & i_wb_we;
  assign w_bm   = {{8{i_wb_sel[3]}}, {8{i_wb_sel[2]}}, {8{i_wb_sel[1]}}, {8{i_wb_sel[0]}}};
  assign w_wd   = i_wb_dat & w_bm;
  assign w_bmn  = N'(w_bm);
  assign w_wdn  = N'(w_wd);
  assign w_unused_hi = ^w_wd;
  assign w_sync = r_sync[SYNC_STAGES-1];
  assign w_clr  = (w_wr && i_wb_adr == A_STAT) ? w_wdn : '0;

  // Edges are masked until the chain and prev hold real post-reset pin values.
  assign w_edge = (r_warm == WARM_DONE)
                ? ((w_sync & ~r_prev & r_rise) | (~w_sync & r_prev & r_fall)) : '0;

  always_comb begin
    w_rd = '0;
    case (i_wb_adr)
      A_DOUT:  w_rd = 32'(r_out);
      A_DIN:   w_rd = 32'(w_sync);
      A_DIR:   w_rd = 32'(r_dir);
      A_EN:    w_rd = 32'(r_en);
      A_RISE:  w_rd = 32'(r_rise);
      A_FALL:  w_rd = 32'(r_fall);
      A_STAT:  w_rd = 32'(r_stat);
      default: w_rd = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out  <= OUT_RESET;
      r_dir  <= '0;
      r_en   <= '0;
      r_rise <= '0;
      r_fall <= '0;
      r_stat <= '0;
      r_prev <= '0;
      for (int unsigned i = 0; i < SYNC_STAGES; i++) r_sync[i] <= '0;
      r_warm <= '0;
      r_ack  <= 1'b0;
      r_irq  <= 1'b0;
      r_dat  <= '0;
    end else begin
      r_ack <= w_req;
      r_dat <= (w_req && !i_wb_we) ? w_rd : '0;
      r_irq <= |(r_stat & r_en);

      r_sync[0] <= i_gpio;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_prev <= w_sync;
      if (r_warm != WARM_DONE) r_warm <= r_warm + 3'd1;

      // A new edge overrides a W1C of the same bit in the same cycle.
      r_stat <= (r_stat & ~w_clr) | w_edge;

      if (w_wr) begin
        case (i_wb_adr)
          A_DOUT:  r_out  <= (r_out  & ~w_bmn) | w_wdn;
          A_DIR:   r_dir  <= (r_dir  & ~w_bmn) | w_wdn;
          A_EN:    r_en   <= (r_en   & ~w_bmn) | w_wdn;
          A_RISE:  r_rise <= (r_rise & ~w_bmn) | w_wdn;
          A_FALL:  r_fall <= (r_fall & ~w_bmn) | w_wdn;
          A_SET:   r_out  <= r_out | w_wdn;
          A_CLR:   r_out  <= r_out & ~w_wdn;
          A_TOG:   r_out  <= r_out ^ w_wdn;
          default: ;
        endcase
      end
    end
  end

  assign o_wb_dat   = r_dat;
  assign o_wb_ack   = r_ack;
  assign o_wb_stall = 1'b0;
  assign o_wb_err   = 1'b0;
  assign o_gpio     = r_out;
  assign o_gpio_oe  = r_dir;
  assign o_irq      = r_irq;

endmodule

// File: tb/tb_wb_gpio.sv
// Bench for wb_gpio: directed scenarios plus randomized bus/pin traffic against a
// cycle-stepped reference model of the register map and the input-lag/edge rules.
module tb_wb_gpio;
  localparam int S = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [11:2] adr;
  logic [31:0] wdat, rdat;
  logic        ack, stall, err, irq;
  logic [7:0]  gpio_i, gpio_o, gpio_oe;

  logic        b_cyc, b_stb, b_we, b_ack, b_stall, b_err, b_irq;
  logic [3:0]  b_sel;
  logic [11:2] b_adr;
  logic [31:0] b_wdat, b_rdat, b_gpio_i, b_gpio_o, b_gpio_oe;

  always #5 clk = ~clk;

  wb_gpio #(.N(8), .SYNC_STAGES(S), .OUT_RESET(8'hA5)) dut (
    .clk(clk), .rst(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we), .i_wb_sel(sel),
    .i_wb_adr(adr), .i_wb_dat(wdat), .o_wb_dat(rdat), .o_wb_ack(ack), .o_wb_stall(stall),
    .o_wb_err(err), .i_gpio(gpio_i), .o_gpio(gpio_o), .o_gpio_oe(gpio_oe), .o_irq(irq));

  wb_gpio #(.N(32), .SYNC_STAGES(2), .OUT_RESET(32'h0)) dut32 (
    .clk(clk), .rst(rst), .i_wb_cyc(b_cyc), .i_wb_stb(b_stb), .i_wb_we(b_we), .i_wb_sel(b_sel),
    .i_wb_adr(b_adr), .i_wb_dat(b_wdat), .o_wb_dat(b_rdat), .o_wb_ack(b_ack), .o_wb_stall(b_stall),
    .o_wb_err(b_err), .i_gpio(b_gpio_i), .o_gpio(b_gpio_o), .o_gpio_oe(b_gpio_oe), .o_irq(b_irq));

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  // Reference model state
  logic [7:0] m_out, m_dir, m_en, m_rise, m_fall, m_stat;
  logic [7:0] pinlog [0:8191];
  int         ecount;
  logic [7:0] g_pins;

  // Synchronised pin value visible after edge x (pins lag S-1 edges behind sampling).
  function automatic logic [7:0] din(input int x);
    int j = x - S + 1;
    if (j < 1) return 8'h00;
    return pinlog[j];
  endfunction

  task automatic model_reset();
    m_out = 8'hA5; m_dir = '0; m_en = '0; m_rise = '0; m_fall = '0; m_stat = '0;
    ecount = 0;
  endtask

  function automatic logic [7:0] lane_op(input logic [7:0] old, input logic [31:0] d,
                                         input logic [3:0] s, input int op);
    logic [7:0] r = old;
    logic [7:0] db = d[7:0];
    if (s[0]) begin
      case (op)
        0: r = db;
        1: r = old | db;
        2: r = old & ~db;
        default: r = old ^ db;
      endcase
    end
    return r;
  endfunction

  task automatic cycle(input logic req, input logic w, input int unsigned idx,
                       input logic [3:0] s, input logic [31:0] d);
    logic [31:0] rd_exp;
    logic [7:0]  cur, prv, ev;
    logic        irq_exp;
    cyc = req; stb = req; we = w; sel = s; adr = idx[9:0]; wdat = d; gpio_i = g_pins;
    rd_exp = 32'h0;
    if (req && !w) begin
      case (idx)
        0: rd_exp = {24'h0, m_out};
        1: rd_exp = {24'h0, din(ecount)};
        2: rd_exp = {24'h0, m_dir};
        3: rd_exp = {24'h0, m_en};
        4: rd_exp = {24'h0, m_rise};
        5: rd_exp = {24'h0, m_fall};
        6: rd_exp = {24'h0, m_stat};
        default: rd_exp = 32'h0;
      endcase
    end
    @(posedge clk);
    ecount++;
    pinlog[ecount] = g_pins;
    ev = 8'h00;
    if (ecount >= S + 2) begin
      cur = din(ecount - 1);
      prv = din(ecount - 2);
      ev = (cur & ~prv & m_rise) | (~cur & prv & m_fall);
    end
    irq_exp = |(m_stat & m_en);
    if (req && w) begin
      case (idx)
        0: m_out  = lane_op(m_out, d, s, 0);
        2: m_dir  = lane_op(m_dir, d, s, 0);
        3: m_en   = lane_op(m_en, d, s, 0);
        4: m_rise = lane_op(m_rise, d, s, 0);
        5: m_fall = lane_op(m_fall, d, s, 0);
        6: if (s[0]) m_stat = m_stat & ~d[7:0];
        7: m_out  = lane_op(m_out, d, s, 1);
        8: m_out  = lane_op(m_out, d, s, 2);
        9: m_out  = lane_op(m_out, d, s, 3);
        default: ;
      endcase
    end
    m_stat = m_stat | ev;
    #1;
    check("ack", {31'h0, ack}, {31'h0, req});
    check("dat", rdat, rd_exp);
    check("gpio_o", {24'h0, gpio_o}, {24'h0, m_out});
    check("gpio_oe", {24'h0, gpio_oe}, {24'h0, m_dir});
    check("irq", {31'h0, irq}, {31'h0, irq_exp});
  endtask

  task automatic wr(input int unsigned idx, input logic [31:0] d);
    cycle(1'b1, 1'b1, idx, 4'hF, d);
  endtask
  task automatic rd(input int unsigned idx);
    cycle(1'b1, 1'b0, idx, 4'hF, 32'h0);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 4'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1; cyc = 0; stb = 0; we = 0; sel = 0; adr = '0; wdat = '0; gpio_i = '0;
    b_cyc = 0; b_stb = 0; b_we = 0; b_sel = 0; b_adr = '0; b_wdat = '0; b_gpio_i = '0;
    g_pins = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_gpio_o", {24'h0, gpio_o}, 32'hA5);
    check("rst_oe", {24'h0, gpio_oe}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_ack", {31'h0, ack}, 32'h0);
    check("rst_stall_err", {30'h0, stall, err}, 32'h0);
    rst = 1'b0;
    model_reset();

    // Reset values and an unmapped offset
    rd(0);
    check("rd_dout_rst", rdat, 32'h0000_00A5);
    rd(12);
    check("rd_unmapped", rdat, 32'h0);

    // Byte-lane gating on both widths
    b_cyc = 1; b_stb = 1; b_we = 1; b_sel = 4'b0001; b_adr = 10'd0; b_wdat = 32'hFFFF_FFFF;
    idle(1);
    b_we = 0; b_sel = 4'hF;
    idle(1);
    b_cyc = 0; b_stb = 0;
    check("w32_ack", {31'h0, b_ack}, 32'h1);
    check("w32_sel", b_rdat, 32'h0000_00FF);
    wr(0, 32'h0000_01FF);
    rd(0);
    check("w8_mask", rdat, 32'h0000_00FF);
    cycle(1'b1, 1'b1, 0, 4'b0010, 32'h0000_0000);
    rd(0);
    check("w8_sel_hi", rdat, 32'h0000_00FF);
    wr(0, 32'hA5);

    // Atomic ops back-to-back
    wr(2, 32'hFF); wr(7, 32'h0F); wr(8, 32'h05); wr(9, 32'hF0);
    check("atomic_gpio_o", {24'h0, gpio_o}, 32'h5A);
    idle(1);

    // Rising edge interrupt, W1C, fall ignored
    wr(4, 32'h01); wr(3, 32'h01);
    g_pins = 8'h01; idle(4);
    rd(6);
    check("irq_stat", rdat, 32'h1);
    check("irq_level", {31'h0, irq}, 32'h1);
    wr(6, 32'h01); idle(2);
    check("irq_cleared", {31'h0, irq}, 32'h0);
    g_pins = 8'h00; idle(4);
    rd(6);
    check("fall_ignored", rdat, 32'h0);

    // W1C colliding with a new rise: set wins
    g_pins = 8'h01; idle(5);
    g_pins = 8'h00; idle(4);
    g_pins = 8'h01; idle(1);
    g_pins = 8'h01; idle(1);
    wr(6, 32'h01);
    rd(6);
    check("w1c_vs_set", rdat, 32'h1);
    check("w1c_irq_hold", {31'h0, irq}, 32'h1);

    // Reset between request and ack, pins high through reset, warm-up masking
    g_pins = 8'hFF;
    cyc = 1; stb = 1; we = 0; adr = 10'd0; gpio_i = 8'hFF;
    #2 rst = 1'b1;
    #1 check("rst_drop_ack", {31'h0, ack}, 32'h0);
    @(posedge clk); #1;
    check("rst_no_ack", {31'h0, ack}, 32'h0);
    cyc = 0; stb = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    wr(4, 32'hFF);
    idle(6);
    rd(6);
    check("warmup_stat", rdat, 32'h0);
    rd(1);
    check("din_ff", rdat, 32'hFF);

    // Randomized traffic
    wr(5, 32'h0F);
    for (int n = 0; n < 800; n++) begin
      int unsigned idx;
      logic [3:0] s;
      if ($urandom_range(0, 3) == 0) g_pins = g_pins ^ (8'($urandom) & 8'($urandom));
      idx = $urandom_range(0, 11);
      if (idx == 11) idx = 1023;
      s = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
      case ($urandom_range(0, 3))
        0: idle(1);
        1: cycle(1'b1, 1'b0, idx, s, $urandom);
        default: cycle(1'b1, 1'b1, idx, s, $urandom);
      endcase
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
